// File: rtl/pipe_mem_wb_if.sv
// MEM/WB boundary bundle: MEM-stage instruction fields in, WB-stage register
// file controls and the upstream stall request out.
interface pipe_mem_wb_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              mvalid;
  logic              mwreg;
  logic              mm2reg;
  logic [REG_AW-1:0] mrn;
  logic [DATA_W-1:0] malu;
  logic [DATA_W-1:0] mmo;
  logic              flush;

  logic              mem_busy;
  logic              wvalid;
  logic              wwreg;
  logic              wm2reg;
  logic [REG_AW-1:0] wrn;
  logic [DATA_W-1:0] walu;
  logic [DATA_W-1:0] wmo;
  logic [DATA_W-1:0] wdi;

  // Upstream (MEM stage) side.
  modport master (
    output mvalid, mwreg, mm2reg, mrn, malu, mmo, flush,
    input  mem_busy, wvalid, wwreg, wm2reg, wrn, walu, wmo, wdi
  );

  // Pipeline-register side.
  modport slave (
    input  mvalid, mwreg, mm2reg, mrn, malu, mmo, flush,
    output mem_busy, wvalid, wwreg, wm2reg, wrn, walu, wmo, wdi
  );
endinterface

// File: rtl/pipe_mem_wb.sv
// MEM/WB pipeline register. Single-cycle capture for ALU ops; loads wait in a
// small FSM for LOAD_LAT cycles of memory latency while stalling upstream.
module pipe_mem_wb #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  pipe_mem_wb_if.slave bus
);

  localparam int  CNT_W   = (LOAD_LAT > 1) ? $clog2(LOAD_LAT + 1) : 1;
  localparam bit  HAS_LAT = (LOAD_LAT > 0);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic [1:0] {WB_BUBBLE, WB_DIRECT, WB_HOLD} wb_sel_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  wb_sel_t           wb_sel;
  logic              hold_load;
  logic              busy_raw;

  logic              hold_wreg;
  logic [REG_AW-1:0] hold_rn;
  logic [DATA_W-1:0] hold_alu;

  logic              wvalid_q, wwreg_q, wm2reg_q;
  logic [REG_AW-1:0] wrn_q;
  logic [DATA_W-1:0] walu_q, wmo_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wb_sel     = WB_BUBBLE;
    hold_load  = 1'b0;
    busy_raw   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!bus.flush && bus.mvalid) begin
          if (bus.mm2reg && HAS_LAT) begin
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
            hold_load  = 1'b1;
            busy_raw   = 1'b1;
          end else begin
            wb_sel = WB_DIRECT;
          end
        end
      end
      S_WAIT: begin
        busy_raw = 1'b1;
        if (bus.flush) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_ONE) begin
          wb_sel     = WB_HOLD;
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Hold registers keep the load's destination while mmo is outstanding.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_wreg <= 1'b0;
      hold_rn   <= '0;
      hold_alu  <= '0;
    end else if (hold_load) begin
      hold_wreg <= bus.mwreg;
      hold_rn   <= bus.mrn;
      hold_alu  <= bus.malu;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wvalid_q <= 1'b0;
      wwreg_q  <= 1'b0;
      wm2reg_q <= 1'b0;
      wrn_q    <= '0;
      walu_q   <= '0;
      wmo_q    <= '0;
    end else begin
      unique case (wb_sel)
        WB_DIRECT: begin
          wvalid_q <= 1'b1;
          wwreg_q  <= bus.mwreg && (bus.mrn != '0);
          wm2reg_q <= bus.mm2reg;
          wrn_q    <= bus.mrn;
          walu_q   <= bus.malu;
          wmo_q    <= bus.mmo;
        end
        WB_HOLD: begin
          wvalid_q <= 1'b1;
          wwreg_q  <= hold_wreg && (hold_rn != '0);
          wm2reg_q <= 1'b1;
          wrn_q    <= hold_rn;
          walu_q   <= hold_alu;
          wmo_q    <= bus.mmo;
        end
        default: begin
          // Bubble: data fields keep their last value, controls are cleared.
          wvalid_q <= 1'b0;
          wwreg_q  <= 1'b0;
          wm2reg_q <= 1'b0;
        end
      endcase
    end
  end

  // Reset masks the stall so upstream is never held by stale inputs.
  assign bus.mem_busy = busy_raw && !reset;
  assign bus.wvalid   = wvalid_q;
  assign bus.wwreg    = wwreg_q;
  assign bus.wm2reg   = wm2reg_q;
  assign bus.wrn      = wrn_q;
  assign bus.walu     = walu_q;
  assign bus.wmo      = wmo_q;
  assign bus.wdi      = wm2reg_q ? wmo_q : walu_q;

endmodule

// File: tb/tb_pipe_mem_wb.sv
// Bench for pipe_mem_wb: directed scenarios plus randomized traffic checked
// against a transaction-level model, on LOAD_LAT=1 and LOAD_LAT=3 instances.
module tb_pipe_mem_wb;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // sel chooses which instance receives real instructions and is observed.
  logic          sel;
  logic          mvalid, mwreg, mm2reg, flush;
  logic [AW-1:0] mrn;
  logic [DW-1:0] malu, mmo;

  pipe_mem_wb_if #(.DATA_W(DW), .REG_AW(AW)) bus1 ();
  pipe_mem_wb_if #(.DATA_W(DW), .REG_AW(AW)) bus3 ();

  assign bus1.mvalid = sel ? 1'b0 : mvalid;
  assign bus3.mvalid = sel ? mvalid : 1'b0;
  assign bus1.mwreg = mwreg;   assign bus3.mwreg = mwreg;
  assign bus1.mm2reg = mm2reg; assign bus3.mm2reg = mm2reg;
  assign bus1.mrn = mrn;       assign bus3.mrn = mrn;
  assign bus1.malu = malu;     assign bus3.malu = malu;
  assign bus1.mmo = mmo;       assign bus3.mmo = mmo;
  assign bus1.flush = flush;   assign bus3.flush = flush;

  wire          o_busy   = sel ? bus3.mem_busy : bus1.mem_busy;
  wire          o_wvalid = sel ? bus3.wvalid   : bus1.wvalid;
  wire          o_wwreg  = sel ? bus3.wwreg    : bus1.wwreg;
  wire          o_wm2reg = sel ? bus3.wm2reg   : bus1.wm2reg;
  wire [AW-1:0] o_wrn    = sel ? bus3.wrn      : bus1.wrn;
  wire [DW-1:0] o_walu   = sel ? bus3.walu     : bus1.walu;
  wire [DW-1:0] o_wmo    = sel ? bus3.wmo      : bus1.wmo;
  wire [DW-1:0] o_wdi    = sel ? bus3.wdi      : bus1.wdi;

  pipe_mem_wb #(.DATA_W(DW), .REG_AW(AW), .LOAD_LAT(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1));
  pipe_mem_wb #(.DATA_W(DW), .REG_AW(AW), .LOAD_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .bus(bus3));

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic m2r,
                       input logic [AW-1:0] rn, input logic [DW-1:0] alu,
                       input logic [DW-1:0] mo, input logic f);
    mvalid = v; mwreg = w; mm2reg = m2r; mrn = rn; malu = alu; mmo = mo; flush = f;
  endtask

  task automatic test_reset();
    sel   = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), $urandom, $urandom,
            1'($urandom));
      tick();
      for (int s = 0; s < 2; s++) begin
        sel = s[0];
        #1;
        total++; if (o_wvalid !== 1'b0) begin bad++; $display("FAIL reset wvalid sel=%0d got=%b exp=0", s, o_wvalid); end
        total++; if (o_wwreg !== 1'b0) begin bad++; $display("FAIL reset wwreg sel=%0d got=%b exp=0", s, o_wwreg); end
        total++; if (o_wm2reg !== 1'b0) begin bad++; $display("FAIL reset wm2reg sel=%0d got=%b exp=0", s, o_wm2reg); end
        total++; if (o_wrn !== '0) begin bad++; $display("FAIL reset wrn sel=%0d got=%0d exp=0", s, o_wrn); end
        total++; if (o_walu !== '0 || o_wmo !== '0 || o_wdi !== '0) begin
          bad++; $display("FAIL reset data sel=%0d walu=%h wmo=%h wdi=%h exp=0", s, o_walu, o_wmo, o_wdi);
        end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset mem_busy sel=%0d got=%b exp=0", s, o_busy); end
      end
      sel = 1'b0;
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    sel = 1'b0;
    drive(1'b1, 1'b1, 1'b0, AW'(5), 32'h0000_00A5, 32'h1234_5678, 1'b0);
    @(negedge clock);
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL alu mem_busy got=%b exp=0", o_busy); end
    tick();
    total++; if (o_wvalid !== 1'b1) begin bad++; $display("FAIL alu wvalid got=%b exp=1", o_wvalid); end
    total++; if (o_wwreg !== 1'b1) begin bad++; $display("FAIL alu wwreg got=%b exp=1", o_wwreg); end
    total++; if (o_wrn !== AW'(5)) begin bad++; $display("FAIL alu wrn got=%0d exp=5", o_wrn); end
    total++; if (o_wdi !== 32'hA5) begin bad++; $display("FAIL alu wdi got=%h exp=000000a5", o_wdi); end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clock);
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL alu mem_busy after got=%b exp=0", o_busy); end
    tick();
    total++; if (o_wvalid !== 1'b0) begin bad++; $display("FAIL alu bubble wvalid got=%b exp=0", o_wvalid); end
  endtask

  // Load on the LOAD_LAT=1 instance; mmo is garbage until the capture cycle.
  task automatic test_load(input logic [AW-1:0] rn, input logic [DW-1:0] data);
    logic exp_wr;
    exp_wr = (rn != '0);
    sel = 1'b0;
    drive(1'b1, 1'b1, 1'b1, rn, 32'h40, ~data, 1'b0);
    @(negedge clock);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL load rn=%0d busy0 got=%b exp=1", rn, o_busy); end
    tick();
    total++; if (o_wvalid !== 1'b0) begin bad++; $display("FAIL load rn=%0d bubble wvalid got=%b exp=0", rn, o_wvalid); end
    mmo = data;
    @(negedge clock);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL load rn=%0d busy1 got=%b exp=1", rn, o_busy); end
    tick();
    total++; if (o_wvalid !== 1'b1) begin bad++; $display("FAIL load rn=%0d wvalid got=%b exp=1", rn, o_wvalid); end
    total++; if (o_wwreg !== exp_wr) begin bad++; $display("FAIL load rn=%0d wwreg got=%b exp=%b", rn, o_wwreg, exp_wr); end
    total++; if (o_wm2reg !== 1'b1) begin bad++; $display("FAIL load rn=%0d wm2reg got=%b exp=1", rn, o_wm2reg); end
    total++; if (o_wrn !== rn) begin bad++; $display("FAIL load wrn got=%0d exp=%0d", o_wrn, rn); end
    total++; if (o_wdi !== data) begin bad++; $display("FAIL load rn=%0d wdi got=%h exp=%h", rn, o_wdi, data); end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clock);
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL load rn=%0d busy end got=%b exp=0", rn, o_busy); end
    tick();
  endtask

  task automatic test_flush_wait();
    sel = 1'b1;
    drive(1'b1, 1'b1, 1'b1, AW'(9), 32'h80, 32'hCAFE_F00D, 1'b0);
    tick();
    total++; if (o_wvalid !== 1'b0) begin bad++; $display("FAIL flush enter wvalid got=%b exp=0", o_wvalid); end
    flush = 1'b1;
    @(negedge clock);
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL flush wait busy got=%b exp=1", o_busy); end
    tick();
    total++; if (o_wvalid !== 1'b0 || o_wwreg !== 1'b0) begin
      bad++; $display("FAIL flush abort wvalid=%b wwreg=%b exp=0,0", o_wvalid, o_wwreg);
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, 32'hCAFE_F00D, 1'b0);
    @(negedge clock);
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL flush idle busy got=%b exp=0", o_busy); end
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (o_wvalid !== 1'b0 || o_wwreg !== 1'b0) begin
        bad++; $display("FAIL flush late write cycle=%0d wvalid=%b wwreg=%b", c, o_wvalid, o_wwreg);
      end
    end
  endtask

  // Load, ALU, load on LOAD_LAT=1, with upstream honouring mem_busy.
  task automatic test_back_to_back();
    logic [AW-1:0] rn_q[$];
    logic [DW-1:0] di_q[$];
    logic [AW-1:0] exp_rn[3];
    logic [DW-1:0] exp_di[3];
    logic          is_ld[3];
    int idx, waited;
    exp_rn = '{AW'(3), AW'(4), AW'(6)};
    exp_di = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    is_ld  = '{1'b1, 1'b0, 1'b1};
    sel = 1'b0;
    idx = 0; waited = 0;
    for (int c = 0; c < 12; c++) begin
      if (idx < 3) begin
        drive(1'b1, 1'b1, is_ld[idx], exp_rn[idx], is_ld[idx] ? 32'h100 : exp_di[idx],
              (is_ld[idx] && waited == 1) ? exp_di[idx] : $urandom, 1'b0);
      end else begin
        drive(1'b0, 1'b0, 1'b0, '0, $urandom, $urandom, 1'b0);
      end
      @(negedge clock);
      if (idx < 3 && o_busy === 1'b1 && waited == 0) waited = 1;
      else if (idx < 3) begin idx++; waited = 0; end
      tick();
      if (o_wvalid === 1'b1 && o_wwreg === 1'b1) begin rn_q.push_back(o_wrn); di_q.push_back(o_wdi); end
    end
    total++; if (rn_q.size() != 3) begin bad++; $display("FAIL b2b write count got=%0d exp=3", rn_q.size()); end
    for (int i = 0; i < 3 && i < rn_q.size(); i++) begin
      total++; if (rn_q[i] !== exp_rn[i] || di_q[i] !== exp_di[i]) begin
        bad++; $display("FAIL b2b write%0d rn=%0d di=%h exp rn=%0d di=%h", i, rn_q[i], di_q[i], exp_rn[i], exp_di[i]);
      end
    end
  endtask

  // Randomized traffic. A load accepted in cycle c writes back at the edge
  // ending cycle c+lat, using the mmo present in that cycle.
  task automatic test_random(input logic s, input int lat, input int n);
    bit            pend;
    int            cap_at;
    logic [AW-1:0] p_rn;
    logic          p_wreg;
    logic [DW-1:0] p_alu;
    logic          e_busy, e_v, e_wr, e_m2;
    logic [AW-1:0] e_rn;
    logic [DW-1:0] e_di;
    sel = s; pend = 0; cap_at = 0; p_rn = '0; p_wreg = 1'b0; p_alu = '0;
    for (int c = 0; c < n + 6; c++) begin
      e_v = 1'b0; e_wr = 1'b0; e_m2 = 1'b0; e_rn = '0; e_di = '0;
      mmo = $urandom;
      if (pend) begin
        drive(1'b1, p_wreg, 1'b1, p_rn, p_alu, mmo, $urandom_range(7) == 0);
        e_busy = 1'b1;
        if (flush) pend = 0;
        else if (c == cap_at) begin
          e_v = 1'b1; e_m2 = 1'b1; e_rn = p_rn; e_wr = p_wreg && (p_rn != '0); e_di = mmo; pend = 0;
        end
      end else begin
        drive((c < n) && ($urandom_range(3) != 0), 1'($urandom), 1'($urandom),
              ($urandom_range(3) == 0) ? '0 : AW'($urandom), $urandom, mmo,
              $urandom_range(9) == 0);
        e_busy = 1'b0;
        if (mvalid && !flush) begin
          if (mm2reg) begin
            e_busy = 1'b1; pend = 1; cap_at = c + lat; p_rn = mrn; p_wreg = mwreg; p_alu = malu;
          end else begin
            e_v = 1'b1; e_rn = mrn; e_wr = mwreg && (mrn != '0); e_di = malu;
          end
        end
      end
      @(negedge clock);
      total++; if (o_busy !== e_busy) begin bad++; $display("FAIL rand lat=%0d c=%0d busy got=%b exp=%b", lat, c, o_busy, e_busy); end
      // Inputs wiggle between edges; only the value at the edge may matter.
      malu = ~malu; mmo = ~mmo; #1; malu = ~malu; mmo = ~mmo;
      tick();
      total++; if (o_wvalid !== e_v || o_wwreg !== e_wr) begin
        bad++; $display("FAIL rand lat=%0d c=%0d wvalid=%b wwreg=%b exp=%b,%b", lat, c, o_wvalid, o_wwreg, e_v, e_wr);
      end
      if (e_v) begin
        total++; if (o_wrn !== e_rn || o_wdi !== e_di || o_wm2reg !== e_m2) begin
          bad++; $display("FAIL rand lat=%0d c=%0d wrn=%0d wdi=%h wm2reg=%b exp=%0d,%h,%b",
                          lat, c, o_wrn, o_wdi, o_wm2reg, e_rn, e_di, e_m2);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    tick();
  endtask

  initial begin
    sel = 1'b0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    test_reset();
    test_alu();
    test_load(AW'(7), 32'hDEAD_BEEF);
    test_load(AW'(0), 32'h0BAD_F00D);
    test_flush_wait();
    test_back_to_back();
    test_random(1'b0, 1, 400);
    test_random(1'b1, 3, 400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
